waveform_mode_ctrl: RTL and testbench
=====================================

// Module: waveform_mode_ctrl
// PURPOSE
// - Multi-channel successor to the single-channel waveform mode FSM. Holds one waveform mode per
//   synth channel and steps it forward or back on key pulses from the keypad debouncer.
// - Skips modes disabled by a mask and reports every mode change to the oscillator bank.
// - Sits between the keypad edge detectors and the per-channel waveform generators.
// PARAMETERS
// - NUM_CH      4        number of channels (>=1)
// - NUM_MODES   4        modes per channel (>=2); mode 0 = OFF (others e.g. 1 SQUARE, 2 SAW, 3 TRI)
// - MODE_W      $clog2(NUM_MODES)  width of one mode field (derived; do not override)
// - CH_W        (NUM_CH>1)?$clog2(NUM_CH):1  width of channel index (derived)
// - MODE_MASK   {NUM_MODES{1'b1}}  bit m=1 -> mode m selectable; bit 0 forced to 1 internally
// - IDLE_CYCLES 100000   auto-off timeout in clk cycles (used only with the macro below; >=1)
// PORTS
// - clk          in   1              system clock (10 kHz)
// - rst          in   1              synchronous reset, active-high
// - next_key     in   1              1-cycle pulse: advance mode of selected channel
// - prev_key     in   1              1-cycle pulse: step mode of selected channel back
// - ch_key       in   1              1-cycle pulse: select next channel
// - cur_ch       out  CH_W           currently selected channel
// - mode         out  NUM_CH*MODE_W  packed modes; channel c at [c*MODE_W +: MODE_W]
// - mode_changed out  1              1-cycle pulse, high in the cycle a new mode value first appears
// - chg_ch       out  CH_W           channel whose mode changed; valid while mode_changed=1
// BEHAVIOUR
// - Clock and reset: single clock domain; reset is synchronous, active-high.
// - Reset values: every mode field = 0 (OFF), cur_ch = 0, mode_changed = 0, chg_ch = 0,
//   idle counters = 0.
// - Reset has priority over all keys. Reset mid-sequence discards the in-flight change:
//   no mode_changed pulse follows.
// - All outputs are registered.
// - Latency: a key sampled at clock edge k is visible on mode/cur_ch immediately after edge k.
//   mode_changed and chg_ch assert in that same cycle.
// - Channel select: on ch_key, cur_ch <= (cur_ch==NUM_CH-1) ? 0 : cur_ch+1.
//   With NUM_CH=1, cur_ch stays 0.
// - Mode step:
//   - next_key sets mode[cur_ch] to the nearest enabled mode strictly after the current one,
//     modulo NUM_MODES.
//   - prev_key sets it to the nearest enabled mode strictly before, modulo NUM_MODES.
//   - Wrap-around: last enabled -> OFF on next; OFF -> last enabled on prev.
// - Mask edge case: if only OFF is enabled, next/prev are no-ops and mode_changed stays 0.
// - next_key and prev_key in the same cycle: no change, no pulse.
// - ch_key together with next/prev: the step applies to the channel selected before the edge
//   (old cur_ch). cur_ch advances in the same edge.
// - mode_changed fires only when the stored value actually differs from its previous value.
// - Non-selected channels hold their mode.
// - The combinational search over NUM_MODES is unrolled; there is no multi-cycle search state.
// CONFIGURATION
// - Macro WAVE_MODE_AUTOOFF_EN defined: per-channel auto-off timer.
//   - Each channel has a counter of width $clog2(IDLE_CYCLES+1).
//   - The counter is cleared on any next/prev pulse targeting that channel, and held at 0
//     while the channel is OFF. Otherwise it increments each cycle.
//   - When the counter reaches IDLE_CYCLES-1 with the channel not OFF: the mode goes to OFF
//     on that edge, mode_changed pulses with chg_ch = that channel, and the counter clears.
//   - A key on that channel in the same cycle wins over the timeout (step applied, counter
//     cleared).
//   - Several channels timing out in the same cycle: all go OFF; chg_ch reports the lowest
//     index. A key-driven change the same cycle takes chg_ch priority.
// - Macro undefined: no counters; modes change only on keys; IDLE_CYCLES unused.
// TESTING
// - Reset, then 4x next_key on ch0 (default mask):
//   ch0 mode 1,2,3,0; mode_changed pulses 4x, chg_ch=0; other channels stay 0.
// - MODE_MASK=4'b1011, ch0 at OFF:
//   next -> 1, next -> 3 (2 skipped), next -> 0; then prev from 0 -> 3.
// - next_key and prev_key together: mode unchanged, mode_changed=0.
//   ch_key and next_key together at cur_ch=3: ch3 steps, cur_ch=0.
// - ch_key 4x with NUM_CH=4: cur_ch 1,2,3,0. Raise rst mid-stream with next_key high:
//   all modes 0, cur_ch 0, no pulse next cycle.
// - WAVE_MODE_AUTOOFF_EN, IDLE_CYCLES=8: ch1 set to 2, no keys.
//   Ch1 goes 0 exactly 8 cycles after the set edge, with a mode_changed pulse and chg_ch=1.
// - WAVE_MODE_AUTOOFF_EN: next_key on ch1 in its timeout cycle -> mode 3, not OFF;
//   timer restarts from 0.

Source files
------------

// File: rtl/waveform_mode_ctrl.sv
// waveform_mode_ctrl: per-channel waveform mode stepper with mask skipping and change pulses; optional auto-off with WAVE_MODE_AUTOOFF_EN
module waveform_mode_ctrl #(
  parameter int NUM_CH = 4,
  parameter int NUM_MODES = 4,
  parameter int MODE_W = $clog2(NUM_MODES),
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter logic [NUM_MODES-1:0] MODE_MASK = {NUM_MODES{1'b1}},
  parameter int IDLE_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     next_key,
  input  logic                     prev_key,
  input  logic                     ch_key,
  output logic [CH_W-1:0]          cur_ch,
  output logic [NUM_CH*MODE_W-1:0] mode,
  output logic                     mode_changed,
  output logic [CH_W-1:0]          chg_ch
);
  localparam logic [NUM_MODES-1:0] EN = MODE_MASK | NUM_MODES'(1);
  logic [NUM_CH-1:0][MODE_W-1:0] mode_q, mode_d;
  logic [CH_W-1:0] cur_q, cur_d, chg_ch_q, chg_ch_d;
  logic chg_q, chg_d;
  logic key, key_chg;
  logic [MODE_W-1:0] stepped;
  logic [NUM_CH-1:0] tmo;
  function automatic logic [MODE_W-1:0] step_mode(input logic [MODE_W-1:0] cur, input logic fwd);
    logic [MODE_W-1:0] r, m;
    r = cur;
    for (int d = NUM_MODES - 1; d >= 1; d--) begin
      m = MODE_W'(fwd ? (int'(cur) + d) % NUM_MODES : (int'(cur) + NUM_MODES - d) % NUM_MODES);
      r = EN[m] ? m : r;
    end
    return r;
  endfunction
  assign key = next_key | prev_key;
`ifdef WAVE_MODE_AUTOOFF_EN
  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  // Idle timers: cleared by a key on the channel, parked at 0 while OFF, expire one cycle before IDLE_CYCLES.
  always_comb begin
    tmo = '0;
    cnt_d = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      tmo[c] = !(key && cur_q == CH_W'(c)) && mode_q[c] != '0 && cnt_q[c] == CNT_W'(IDLE_CYCLES - 1);
      cnt_d[c] = ((key && cur_q == CH_W'(c)) || tmo[c] || mode_q[c] == '0) ? '0 : cnt_q[c] + CNT_W'(1);
    end
  end
  // Idle counter registers.
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
  end
`else
  assign tmo = '0;
`endif
  // Next state: channel select, keyed step on the old channel, timeouts, and change reporting.
  always_comb begin
    cur_d = ch_key ? ((cur_q == CH_W'(NUM_CH - 1)) ? '0 : cur_q + CH_W'(1)) : cur_q;
    stepped = (next_key ^ prev_key) ? step_mode(mode_q[cur_q], next_key) : mode_q[cur_q];
    key_chg = stepped != mode_q[cur_q];
    mode_d = mode_q;
    chg_ch_d = chg_ch_q;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      mode_d[c] = tmo[c] ? '0 : mode_d[c];
      chg_ch_d = tmo[c] ? CH_W'(c) : chg_ch_d;
    end
    mode_d[cur_q] = key ? stepped : mode_d[cur_q];
    chg_ch_d = key_chg ? cur_q : chg_ch_d;
    chg_d = key_chg | (|tmo);
  end
  // State registers; reset drops any change in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      cur_q <= '0;
      chg_q <= 1'b0;
      chg_ch_q <= '0;
    end else begin
      mode_q <= mode_d;
      cur_q <= cur_d;
      chg_q <= chg_d;
      chg_ch_q <= chg_ch_d;
    end
  end
  assign mode = mode_q;
  assign cur_ch = cur_q;
  assign mode_changed = chg_q;
  assign chg_ch = chg_ch_q;
endmodule

// File: tb/tb_waveform_mode_ctrl.sv
// tb_waveform_mode_ctrl: table-driven scoreboard bench for waveform_mode_ctrl (default and masked builds, auto-off when enabled)
module tb_waveform_mode_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, next_key = 1'b0, prev_key = 1'b0, ch_key = 1'b0;
  logic [1:0] cur_a, cur_b, cur_c, cc_a, cc_b, cc_c;
  logic [7:0] mode_a, mode_b, mode_c;
  logic chg_a, chg_b, chg_c;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  waveform_mode_ctrl #(.IDLE_CYCLES(1000)) u_a (
    .clk(clk), .rst(rst), .next_key(next_key), .prev_key(prev_key), .ch_key(ch_key),
    .cur_ch(cur_a), .mode(mode_a), .mode_changed(chg_a), .chg_ch(cc_a));
  waveform_mode_ctrl #(.MODE_MASK(4'b1011), .IDLE_CYCLES(1000)) u_b (
    .clk(clk), .rst(rst), .next_key(next_key), .prev_key(prev_key), .ch_key(ch_key),
    .cur_ch(cur_b), .mode(mode_b), .mode_changed(chg_b), .chg_ch(cc_b));
  waveform_mode_ctrl #(.IDLE_CYCLES(8)) u_c (
    .clk(clk), .rst(rst), .next_key(next_key), .prev_key(prev_key), .ch_key(ch_key),
    .cur_ch(cur_c), .mode(mode_c), .mode_changed(chg_c), .chg_ch(cc_c));
  typedef struct {
    logic [1:0] sel;
    logic [1:0] cur;
    logic [7:0] mode;
    logic chg;
    logic [1:0] cc;
  } exp_t;
  typedef struct {
    logic nk, pk, ck;
    logic [1:0] cur;
    logic [7:0] ma;
    logic ca;
    logic [1:0] cca;
    logic [7:0] mb;
    logic cb;
    logic [1:0] ccb;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[19];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [1:0] sel, input logic [1:0] cur, input logic [7:0] m, input logic chg, input logic [1:0] cc);
    exp_t e;
    e.sel = sel; e.cur = cur; e.mode = m; e.chg = chg; e.cc = cc;
    sb.push_back(e);
  endtask
  task automatic drain(input string tag);
    exp_t e;
    logic [1:0] c, k;
    logic [7:0] m;
    logic g;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      c = e.sel == 0 ? cur_a : e.sel == 1 ? cur_b : cur_c;
      k = e.sel == 0 ? cc_a : e.sel == 1 ? cc_b : cc_c;
      m = e.sel == 0 ? mode_a : e.sel == 1 ? mode_b : mode_c;
      g = e.sel == 0 ? chg_a : e.sel == 1 ? chg_b : chg_c;
      check($sformatf("%s dut%0d cur_ch", tag, e.sel), 32'(c), 32'(e.cur));
      check($sformatf("%s dut%0d mode", tag, e.sel), 32'(m), 32'(e.mode));
      check($sformatf("%s dut%0d mode_changed", tag, e.sel), 32'(g), 32'(e.chg));
      if (e.chg) check($sformatf("%s dut%0d chg_ch", tag, e.sel), 32'(k), 32'(e.cc));
    end
  endtask
  task automatic step(input logic nk, input logic pk, input logic ck, input string tag);
    next_key = nk; prev_key = pk; ch_key = ck;
    @(posedge clk);
    #1;
    next_key = 1'b0; prev_key = 1'b0; ch_key = 1'b0;
    drain(tag);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h01, 1'b1, 2'd0, 8'h01, 1'b1, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h02, 1'b1, 2'd0, 8'h03, 1'b1, 2'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h03, 1'b1, 2'd0, 8'h00, 1'b1, 2'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h01, 1'b1, 2'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h03, 1'b1, 2'd0, 8'h00, 1'b1, 2'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h02, 1'b1, 2'd0, 8'h03, 1'b1, 2'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h02, 1'b0, 2'd0, 8'h03, 1'b0, 2'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h02, 1'b0, 2'd0, 8'h03, 1'b0, 2'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h02, 1'b0, 2'd0, 8'h03, 1'b0, 2'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'd1, 8'h06, 1'b1, 2'd1, 8'h07, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h06, 1'b0, 2'd0, 8'h07, 1'b0, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd3, 8'h06, 1'b0, 2'd0, 8'h07, 1'b0, 2'd0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h46, 1'b1, 2'd3, 8'h47, 1'b1, 2'd3};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h47, 1'b1, 2'd0, 8'h44, 1'b1, 2'd0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h46, 1'b1, 2'd0, 8'h47, 1'b1, 2'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h46, 1'b0, 2'd0, 8'h47, 1'b0, 2'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h46, 1'b0, 2'd0, 8'h47, 1'b0, 2'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 2'd3, 8'h46, 1'b0, 2'd0, 8'h47, 1'b0, 2'd0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h46, 1'b0, 2'd0, 8'h47, 1'b0, 2'd0};
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) push(2'(s), 2'd0, 8'h00, 1'b0, 2'd0);
    drain("reset");
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      push(2'd0, tbl[i].cur, tbl[i].ma, tbl[i].ca, tbl[i].cca);
      push(2'd1, tbl[i].cur, tbl[i].mb, tbl[i].cb, tbl[i].ccb);
      step(tbl[i].nk, tbl[i].pk, tbl[i].ck, $sformatf("vec%0d", i));
    end
    step(1'b0, 1'b0, 1'b1, "pre_rst_ch");
    step(1'b1, 1'b0, 1'b0, "pre_rst_next");
    rst = 1'b1;
    for (int s = 0; s < 3; s++) push(2'(s), 2'd0, 8'h00, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b0, "rst_with_next");
    rst = 1'b0;
    for (int s = 0; s < 3; s++) push(2'(s), 2'd0, 8'h00, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, "after_rst");
`ifdef WAVE_MODE_AUTOOFF_EN
    step(1'b0, 1'b0, 1'b1, "ao_sel");
    step(1'b1, 1'b0, 1'b0, "ao_set1");
    push(2'd2, 2'd1, 8'h08, 1'b1, 2'd1);
    step(1'b1, 1'b0, 1'b0, "ao_set2");
    for (int j = 1; j <= 8; j++) begin
      push(2'd2, 2'd1, (j < 8) ? 8'h08 : 8'h00, j == 8, 2'd1);
      step(1'b0, 1'b0, 1'b0, $sformatf("ao_idle%0d", j));
    end
    push(2'd2, 2'd1, 8'h04, 1'b1, 2'd1);
    step(1'b1, 1'b0, 1'b0, "ao_reset1");
    push(2'd2, 2'd1, 8'h08, 1'b1, 2'd1);
    step(1'b1, 1'b0, 1'b0, "ao_reset2");
    for (int j = 1; j <= 7; j++) begin
      push(2'd2, 2'd1, 8'h08, 1'b0, 2'd1);
      step(1'b0, 1'b0, 1'b0, $sformatf("ao_wait%0d", j));
    end
    push(2'd2, 2'd1, 8'h0C, 1'b1, 2'd1);
    step(1'b1, 1'b0, 1'b0, "ao_key_wins");
    for (int j = 1; j <= 8; j++) begin
      push(2'd2, 2'd1, (j < 8) ? 8'h0C : 8'h00, j == 8, 2'd1);
      step(1'b0, 1'b0, 1'b0, $sformatf("ao_restart%0d", j));
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
